wshb_arbiter: RTL and testbench

- Shares the single Wishbone master port of the HPS bridge (the SDRAM path) between two Wishbone masters.
- Typical pairing: m0 is the video frame reader, m1 is the pattern/frame writer.
- Round-robin arbitration. Ownership is held for the whole duration of the owner's cyc.
- Slave-side signals are muxed from a registered grant, so the arbiter adds no combinational path from one master to the other.

---
 rtl/wshb_arbiter.sv | 147 ++++++++++++++
 tb/tb_wshb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: two Wishbone masters share one slave port, round-robin, grant held for a whole cyc.
// Define ARB_BURST_LIMIT_EN to preempt an owner after MAX_BURST acks while the other master waits.
//   state | meaning
//   IDLE  | no owner, slave strobes low
//   OWN0  | master 0 drives the slave
//   OWN1  | master 1 drives the slave
module wshb_arbiter #(
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32,
  parameter int MAX_BURST = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic [DAT_W-1:0]   m0_dat_ms,
  output logic [DAT_W-1:0]   m0_dat_sm,
  output logic               m0_ack,
  output logic               m0_rty,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic [DAT_W-1:0]   m1_dat_ms,
  output logic [DAT_W-1:0]   m1_dat_sm,
  output logic               m1_ack,
  output logic               m1_rty,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W/8-1:0] s_sel,
  output logic [DAT_W-1:0]   s_dat_ms,
  input  logic [DAT_W-1:0]   s_dat_sm,
  input  logic               s_ack,
  input  logic               s_rty
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   preempt0, preempt1;

`ifdef ARB_BURST_LIMIT_EN
  logic [15:0] burst_cnt;
  logic        limit_hit;

  // Preemption is only taken on an ack, so a transfer never straddles owners.
  assign limit_hit = s_ack && (({1'b0, burst_cnt} + 17'd1) >= 17'(MAX_BURST));
  assign preempt0  = limit_hit && m1_cyc;
  assign preempt1  = limit_hit && m0_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      burst_cnt <= '0;
    else if (state_nxt != state)
      burst_cnt <= '0;
    else if (state != IDLE && s_ack && burst_cnt != 16'hFFFF)
      burst_cnt <= burst_cnt + 16'd1;
  end
`else
  localparam int unused_max_burst = MAX_BURST;
  assign preempt0 = 1'b0;
  assign preempt1 = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc)
          state_nxt = last ? OWN0 : OWN1;
        else if (m0_cyc)
          state_nxt = OWN0;
        else if (m1_cyc)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_cyc || preempt0) begin
          state_nxt = m1_cyc ? OWN1 : IDLE;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc || preempt1) begin
          state_nxt = m0_cyc ? OWN0 : IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = m0_adr;
    s_sel    = m0_sel;
    s_dat_ms = m0_dat_ms;
    m0_ack   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_rty   = 1'b0;
    case (state)
      OWN0: begin
        s_cyc  = m0_cyc;
        s_stb  = m0_stb;
        s_we   = m0_we;
        m0_ack = s_ack;
        m0_rty = s_rty;
      end
      OWN1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_ms = m1_dat_ms;
        m1_ack   = s_ack;
        m1_rty   = s_rty;
      end
      default: ;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: scoreboarded bench for wshb_arbiter with a wait-state slave model.
module tb_wshb_arbiter;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mcyc, mstb, mwe, mack, mrty;
  logic [31:0] madr [2];
  logic [3:0]  msel [2];
  logic [31:0] mdat [2];
  logic [31:0] m0_dat_sm, m1_dat_sm;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic        sl_ack, force_ack, force_rty;
  logic        s_ack, s_rty;

  int   n_checks = 0;
  int   n_errors = 0;
  txn_t exp_q0[$];
  txn_t exp_q1[$];
  int   exp_grant[$];
  int   ack_cnt;

  assign s_ack = sl_ack | force_ack;
  assign s_rty = force_rty;

  always #5 clk = ~clk;

  wshb_arbiter #(.ADR_W(32), .DAT_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_adr(madr[0]),
    .m0_sel(msel[0]), .m0_dat_ms(mdat[0]), .m0_dat_sm(m0_dat_sm),
    .m0_ack(mack[0]), .m0_rty(mrty[0]),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_adr(madr[1]),
    .m1_sel(msel[1]), .m1_dat_ms(mdat[1]), .m1_dat_sm(m1_dat_sm),
    .m1_ack(mack[1]), .m1_rty(mrty[1]),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_rty(s_rty)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Slave: acks after slave_wait idle cycles, one ack per strobe.
  int          slave_wait = 0;
  int          wcnt = 0;
  logic        req_smp, ack_smp, we_smp, sl_we;
  logic [31:0] adr_smp, dat_smp, sl_adr, sl_dat;

  always begin
    @(negedge clk);
    req_smp = s_cyc && s_stb;
    ack_smp = s_ack;
    adr_smp = s_adr;
    dat_smp = s_dat_ms;
    we_smp  = s_we;
    @(posedge clk);
    #1;
    if (rst || !req_smp || ack_smp) begin
      sl_ack = 1'b0;
      wcnt   = 0;
    end else if (wcnt >= slave_wait) begin
      sl_ack   = 1'b1;
      s_dat_sm = rd_data(adr_smp);
      sl_adr   = adr_smp;
      sl_we    = we_smp;
      sl_dat   = dat_smp;
      wcnt     = 0;
    end else begin
      wcnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst && mack != 2'b00)
      check_val("ack_onehot", $countones(mack), 1);
  end

  task automatic score_ack(input int m);
    txn_t        e;
    logic [31:0] rd;
    if (m == 0) begin
      e  = exp_q0.pop_front();
      rd = m0_dat_sm;
    end else begin
      e  = exp_q1.pop_front();
      rd = m1_dat_sm;
    end
    check_val("sb_adr", sl_adr, e.adr);
    check_val("sb_we", 32'(sl_we), 32'(e.we));
    if (e.we)
      check_val("sb_wdat", sl_dat, e.dat);
    else
      check_val("sb_rdat", rd, rd_data(e.adr));
    if (exp_grant.size() == 0)
      check_val("grant_extra", 32'(m), 32'hFFFF_FFFF);
    else
      check_val("grant_order", 32'(m), 32'(exp_grant.pop_front()));
  endtask

  task automatic wb_master(input int m, input int n, input logic [31:0] base,
                           input logic we, input logic [31:0] wdat);
    txn_t t;
    logic got;
    int   tmo;
    for (int i = 0; i < n; i++) begin
      t.adr   = base + 32'(i * 4);
      t.we    = we;
      t.dat   = wdat + 32'(i);
      mcyc[m] = 1'b1;
      mstb[m] = 1'b1;
      mwe[m]  = we;
      madr[m] = t.adr;
      mdat[m] = t.dat;
      msel[m] = 4'hF;
      if (m == 0) exp_q0.push_back(t);
      else        exp_q1.push_back(t);
      got = 1'b0;
      tmo = 0;
      while (!got && tmo < 400) begin
        @(negedge clk);
        got = mack[m];
        if (got) score_ack(m);
        @(posedge clk);
        #1;
        tmo++;
      end
      if (!got) check_val("ack_timeout", 32'(got), 1);
    end
    mcyc[m] = 1'b0;
    mstb[m] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mcyc      = '0;
    mstb      = '0;
    mwe       = '0;
    force_ack = 1'b0;
    force_rty = 1'b0;
    sl_ack    = 1'b0;
    s_dat_sm  = '0;
    for (int i = 0; i < 2; i++) begin
      madr[i] = '0;
      msel[i] = '0;
      mdat[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_val("rst_s_cyc", 32'(s_cyc), 0);
    check_val("rst_s_stb", 32'(s_stb), 0);
    check_val("rst_ack", 32'(mack), 0);
    check_val("rst_rty", 32'(mrty), 0);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Simultaneous request after reset, then handover with no idle gap.
    for (int i = 0; i < 4; i++) exp_grant.push_back(0);
    exp_grant.push_back(1);
    fork
      begin
        wb_master(0, 4, 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check_val("handover_cyc", 32'(s_cyc), 1);
        check_val("handover_adr", s_adr, 32'h200);
      end
      wb_master(1, 1, 32'h200, 1'b0, 32'h0);
      begin
        @(negedge clk);
        check_val("req_latency", 32'(s_cyc), 0);
        @(negedge clk);
        check_val("first_grant_cyc", 32'(s_cyc), 1);
        check_val("first_grant_adr", s_adr, 32'h100);
      end
    join
    idle(2);

    // Both masters keep requesting: tenures must alternate.
    for (int i = 0; i < 5; i++) begin
      exp_grant.push_back(0);
      exp_grant.push_back(1);
    end
    fork
      for (int t = 0; t < 5; t++) begin
        wb_master(0, 1, 32'h1000 + 32'(t * 16), 1'b0, 32'h0);
        idle(1);
      end
      for (int t = 0; t < 5; t++) begin
        wb_master(1, 1, 32'h2000 + 32'(t * 16), 1'b0, 32'h0);
        idle(1);
      end
    join
    idle(2);

    // Write with three slave wait states.
    slave_wait = 3;
    exp_grant.push_back(0);
    ack_cnt = 0;
    fork
      wb_master(0, 1, 32'h300, 1'b1, 32'hDEADBEEF);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (s_cyc && s_stb) check_val("wait_dat_hold", s_dat_ms, 32'hDEADBEEF);
        if (mack[0]) ack_cnt++;
      end
    join
    check_val("wait_ack_count", 32'(ack_cnt), 1);
    idle(2);

    // Reset while master 1 owns with a strobe pending.
    slave_wait = 10;
    mcyc[1] = 1'b1;
    mstb[1] = 1'b1;
    mwe[1]  = 1'b0;
    madr[1] = 32'h400;
    @(negedge clk);
    @(negedge clk);
    check_val("own1_cyc", 32'(s_cyc), 1);
    check_val("own1_adr", s_adr, 32'h400);
    force_rty = 1'b1;
    #1;
    check_val("rty_owner", 32'(mrty[1]), 1);
    check_val("rty_other", 32'(mrty[0]), 0);
    force_rty = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_val("rst_mid_cyc", 32'(s_cyc), 0);
    check_val("rst_mid_stb", 32'(s_stb), 0);
    check_val("rst_mid_ack", 32'(mack), 0);
    mcyc = '0;
    mstb = '0;
    idle(1);
    rst     = 1'b0;
    madr[0] = 32'h500;
    madr[1] = 32'h600;
    mcyc    = 2'b11;
    mstb    = 2'b11;
    @(negedge clk);
    check_val("tie_latency", 32'(s_cyc), 0);
    @(negedge clk);
    check_val("tie_m0_cyc", 32'(s_cyc), 1);
    check_val("tie_m0_adr", s_adr, 32'h500);
    idle(1);
    mcyc = '0;
    mstb = '0;
    @(negedge clk);
    @(negedge clk);
    force_ack = 1'b1;
    force_rty = 1'b1;
    #1;
    check_val("idle_ack_ignored", 32'(mack), 0);
    check_val("idle_rty_ignored", 32'(mrty), 0);
    force_ack = 1'b0;
    force_rty = 1'b0;
    idle(1);
    slave_wait = 0;
    idle(2);

    // Long master 0 burst with master 1 arriving shortly after.
`ifdef ARB_BURST_LIMIT_EN
    for (int i = 0; i < 4; i++) exp_grant.push_back(0);
    exp_grant.push_back(1);
    for (int i = 0; i < 4; i++) exp_grant.push_back(0);
`else
    for (int i = 0; i < 8; i++) exp_grant.push_back(0);
    exp_grant.push_back(1);
`endif
    fork
      wb_master(0, 8, 32'h700, 1'b0, 32'h0);
      begin
        idle(2);
        wb_master(1, 1, 32'h800, 1'b0, 32'h0);
      end
    join
    idle(3);

    check_val("sb_q0_empty", 32'(exp_q0.size()), 0);
    check_val("sb_q1_empty", 32'(exp_q1.size()), 0);
    check_val("grant_q_empty", 32'(exp_grant.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
